// File: rtl/fetch_pkg.sv
// Shared RV32I pipeline definitions: the IF/ID record and constants that are
// common to fetch, decode and the hazard unit.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] ins;
        logic            valid;
    } if_id_t;

    // A bubble decodes as addi x0,x0,0, so it never writes architectural state.
    localparam if_id_t IF_ID_BUBBLE = '{
        pc:       32'h0000_0000,
        pc_plus4: 32'h0000_0000,
        ins:      NOP_INSTR,
        valid:    1'b0
    };

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/redirect control in, instruction memory port and
// IF/ID register contents out.
interface fetch_if #(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  stall;
    logic                  flush;
    logic [PC_WIDTH-1:0]   branch_target;
    logic [DATA_WIDTH-1:0] imem_data;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic [PC_WIDTH-1:0]   pc_out;
    logic [PC_WIDTH-1:0]   pc_plus4_out;
    logic [DATA_WIDTH-1:0] ins_out;
    logic                  valid_out;

    modport master (
        input  stall,
        input  flush,
        input  branch_target,
        input  imem_data,
        output imem_addr,
        output pc_out,
        output pc_plus4_out,
        output ins_out,
        output valid_out
    );

    modport slave (
        output stall,
        output flush,
        output branch_target,
        output imem_data,
        input  imem_addr,
        input  pc_out,
        input  pc_plus4_out,
        input  ins_out,
        input  valid_out
    );
endinterface

// File: rtl/fetch_if_id_reg.sv
// Generic IF/ID pipeline register: load when enabled, bubble on clear or reset.
module if_id_reg
    import rv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   clr,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t r_q;

    // Pipeline register: reset and clear both inject a bubble; clear beats enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= IF_ID_BUBBLE;
        end else if (clr) begin
            r_q <= IF_ID_BUBBLE;
        end else if (en) begin
            r_q <= d;
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: program counter, next-PC selection and the IF/ID
// register feeding decode.
module fetch
    import rv_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [PC_WIDTH-1:0] w_target_aligned;
    if_id_t              w_if_id_d;
    if_id_t              w_if_id_q;

    // Wraps modulo 2^PC_WIDTH by construction.
    assign w_pc_plus4       = r_pc + PC_STEP;
    assign w_target_aligned = {bus.branch_target[PC_WIDTH-1:2], 2'b00};

    // Next-PC selection: redirect beats stall, otherwise step to the next word.
    always_comb begin
        w_pc_next = r_pc;
        if (bus.flush) begin
            w_pc_next = w_target_aligned;
        end else if (bus.stall) begin
            w_pc_next = r_pc;
        end else begin
            w_pc_next = w_pc_plus4;
        end
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Candidate IF/ID contents for the instruction currently being fetched.
    always_comb begin
        w_if_id_d          = IF_ID_BUBBLE;
        w_if_id_d.pc       = XLEN'(r_pc);
        w_if_id_d.pc_plus4 = XLEN'(w_pc_plus4);
        w_if_id_d.ins      = XLEN'(bus.imem_data);
        w_if_id_d.valid    = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk (clk),
        .rst (rst),
        .en  (~bus.stall),
        .clr (bus.flush),
        .d   (w_if_id_d),
        .q   (w_if_id_q)
    );

    assign bus.imem_addr    = r_pc;
    assign bus.pc_out       = PC_WIDTH'(w_if_id_q.pc);
    assign bus.pc_plus4_out = PC_WIDTH'(w_if_id_q.pc_plus4);
    assign bus.ins_out      = DATA_WIDTH'(w_if_id_q.ins);
    assign bus.valid_out    = w_if_id_q.valid;

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: directed steps queue their expected post-edge
// state, a monitor pops and compares one entry per cycle.
module tb_fetch;
    import rv_pkg::*;

    logic clk;
    logic rst_a;
    logic rst_b;

    fetch_if #(.PC_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    fetch_if #(.PC_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

    fetch #(.DATA_WIDTH(32), .PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.master)
    );

    fetch #(.DATA_WIDTH(32), .PC_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.master)
    );

    typedef struct {
        bit          sel;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ins;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    // Instruction memory model: data differs from address so ins and pc are distinguishable.
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    always_comb bus_a.imem_data = data_of(bus_a.imem_addr);
    always_comb bus_b.imem_data = data_of(bus_b.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, compared 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (!e.sel) begin
                    check("a_imem_addr", bus_a.imem_addr, e.addr);
                    check("a_pc_out", bus_a.pc_out, e.pc);
                    check("a_pc_plus4", bus_a.pc_plus4_out, e.pc4);
                    check("a_ins_out", bus_a.ins_out, e.ins);
                    check("a_valid", {31'h0, bus_a.valid_out}, {31'h0, e.valid});
                end else begin
                    check("b_imem_addr", bus_b.imem_addr, e.addr);
                    check("b_pc_out", bus_b.pc_out, e.pc);
                    check("b_pc_plus4", bus_b.pc_plus4_out, e.pc4);
                    check("b_ins_out", bus_b.ins_out, e.ins);
                    check("b_valid", {31'h0, bus_b.valid_out}, {31'h0, e.valid});
                end
            end
        end
    end

    task automatic step(input logic r, input logic s, input logic f, input logic [31:0] tgt,
                        input bit sel, input logic [31:0] ea, input logic [31:0] ep,
                        input logic [31:0] ep4, input logic [31:0] ei, input logic ev);
        exp_t e;
        rst_a               = r;
        bus_a.stall         = s;
        bus_a.flush         = f;
        bus_a.branch_target = tgt;
        e.sel   = sel;
        e.addr  = ea;
        e.pc    = ep;
        e.pc4   = ep4;
        e.ins   = ei;
        e.valid = ev;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        checks = 0;
        errors = 0;
        rst_b               = 1'b1;
        bus_b.stall         = 1'b0;
        bus_b.flush         = 1'b0;
        bus_b.branch_target = 32'h0;

        // rst stall flush target | sel addr pc pc4 ins valid
        step(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h0,   NOP,                 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h4,   32'h0,   32'h4,   data_of(32'h0),      1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h8,   32'h4,   32'h8,   data_of(32'h4),      1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'hC,   32'h8,   32'hC,   data_of(32'h8),      1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  32'hC,   32'h10,  data_of(32'hC),      1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h10, 32'hC, 32'h10, data_of(32'hC),      1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h14,  32'h10,  32'h14,  data_of(32'h10),     1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h18,  32'h14,  32'h18,  data_of(32'h14),     1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h1C,  32'h18,  32'h1C,  data_of(32'h18),     1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h20,  32'h1C,  32'h20,  data_of(32'h1C),     1'b1);
        // redirect from 0x20 to 0x100
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h100, 32'h0,   32'h0,   NOP,                 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h104, 32'h100, 32'h104, data_of(32'h100),    1'b1);
        // flush beats stall, misaligned target truncated
        step(1'b0, 1'b1, 1'b1, 32'h43,  1'b0, 32'h40,  32'h0,   32'h0,   NOP,                 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h40,  32'h0,   32'h0,   NOP,                 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h44,  32'h40,  32'h44,  data_of(32'h40),     1'b1);
        // back-to-back flushes: last one wins
        step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h200, 32'h0,   32'h0,   NOP,                 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h305, 1'b0, 32'h304, 32'h0,   32'h0,   NOP,                 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h308, 32'h304, 32'h308, data_of(32'h304),    1'b1);
        // reset overrides stall and flush together
        step(1'b1, 1'b1, 1'b1, 32'h80,  1'b0, 32'h0,   32'h0,   32'h0,   NOP,                 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h0,   NOP,                 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h4,   32'h0,   32'h4,   data_of(32'h0),      1'b1);

        // Second instance: PC wraps from 0xFFFF_FFFC to 0
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hFFFF_FFF8, 32'h0, 32'h0, NOP,               1'b0);
        rst_b = 1'b0;
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
             data_of(32'hFFFF_FFF8), 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'hFFFF_FFFC, 32'h0,
             data_of(32'hFFFF_FFFC), 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h0,   32'h4,   data_of(32'h0),      1'b1);

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of `decode`. Holds the program counter, presents it to instruction memory, and captures the IF/ID pipeline register that drives `decode`'s `pc_out`, `pc_plus4_out` and `ins_out` inputs. Honours stall requests from the hazard unit and redirect/flush requests from the execute stage's branch resolution.

## Interface
Parameters:
- `DATA_WIDTH`, 32, instruction width
- `PC_WIDTH`, 32, program-counter width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `stall`  in  1  hazard unit: hold PC and IF/ID
- `flush`  in  1  EX stage: branch/jump taken, redirect and squash
- `branch_target`  in  PC_WIDTH  redirect address, valid when `flush`=1
- `imem_data`  in  DATA_WIDTH  instruction memory read data (combinational from `imem_addr`)
- `imem_addr`  out  PC_WIDTH  current PC to instruction memory
- `pc_out`  out  PC_WIDTH  IF/ID: PC of captured instruction
- `pc_plus4_out`  out  PC_WIDTH  IF/ID: that PC + 4
- `ins_out`  out  DATA_WIDTH  IF/ID: captured instruction
- `valid_out`  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- State: PC register; IF/ID register {pc, pc_plus4, ins, valid}.
- `imem_addr` = PC register, combinational; no other logic in that path.
- Per rising edge, priority rst > flush > stall > advance:
  - rst: PC <= `RESET_PC`; IF/ID <= {0, 0, NOP, 0}.
  - flush: PC <= {branch_target[31:2], 2'b00}; IF/ID <= {0, 0, NOP, 0}. Overrides `stall`.
  - stall (flush=0): PC and IF/ID hold all fields unchanged.
  - advance: IF/ID <= {PC, PC+4, imem_data, 1}; PC <= PC+4.
- NOP = 32'h0000_0013 (`addi x0,x0,0`); bubbles decode as harmless, with no register or memory write.
- `branch_target[1:0]` is always discarded; the stage never fetches misaligned addresses.
- Arithmetic: PC+4 is modulo 2^PC_WIDTH; PC 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- `pc_plus4_out` is registered, never recomputed from `pc_out` at the output.

## Timing
- Reset values: `imem_addr`=`RESET_PC`, `pc_out`=0, `pc_plus4_out`=0, `ins_out`=32'h0000_0013, `valid_out`=0.
- Latency: an instruction at address A appears on `ins_out` one cycle after `imem_addr`=A, provided neither stall nor flush is asserted at that edge.
- First valid instruction after reset release: `imem_addr`=`RESET_PC` in cycle 0; `valid_out`=1 with `pc_out`=`RESET_PC` in cycle 1.
- Redirect: if `flush` is sampled at edge N, then after N: `imem_addr`=target and IF/ID is a bubble. After N+1: target instruction is in IF/ID. Penalty is one IF/ID bubble; the squashing of ID/EX is owned downstream.
- Stall held k cycles freezes all outputs for k cycles; on release the next edge advances normally.
- Back-to-back flushes: each flush reloads the PC; the last one wins.
- `rst` asserted mid-stall or mid-flush overrides both at that edge.

## Structure
- Shared package `rv_pkg`: `NOP_INSTR` = 32'h0000_0013, `RESET_PC_DEFAULT`, and a `if_id_t` packed struct {pc, pc_plus4, ins, valid}. The struct is reused by `decode` and the hazard unit.
- One sub-module, `if_id_reg`: a generic pipeline register with `clk`, `rst`, `en` (=~stall), `clr` (=flush), `d`/`q` of type `if_id_t`. When `clr` is asserted, it loads the bubble value.
- The PC register and next-PC mux live in `fetch` itself.

## Test plan
- Reset, then free-run with imem returning {addr} as data: `pc_out` steps 0, 4, 8; `ins_out`=0, 4, 8; `pc_plus4_out`=4, 8, 12; `valid_out`=1 from cycle 1.
- Stall for 3 cycles at PC=0x10: `imem_addr` holds 0x10 and IF/ID holds {0xC, 0x10, data(0xC), 1}. The cycle after release captures 0x10.
- Flush with target 0x100 while at PC=0x20: next cycle `imem_addr`=0x100, `ins_out`=0x13, `valid_out`=0. The following cycle `pc_out`=0x100.
- Flush and stall together, target 0x43: the flush wins, and `imem_addr`=0x40.
- `RESET_PC`=32'hFFFF_FFF8: the PC sequence is ...F8, ...FC, 0x0. IF/ID shows `pc_plus4_out`=0x0 for `pc_out`=0xFFFF_FFFC.
- `rst` asserted while stall=1 and flush=1: all outputs return to their reset values at the next edge.
